nco_sweep_ctrl: RTL and testbench

//  Sequences the freq input of nco_sin to sweep between two frequency words. Uses

---
 rtl/nco_sweep_ctrl_if.sv | 29 ++
 rtl/nco_sweep_ctrl.sv | 131 +++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/nco_sweep_ctrl_if.sv
// Control/status bundle between the effect registers (master) and the sweep sequencer (slave).
interface nco_sweep_ctrl_if #(
   parameter int FREQ_WIDTH  = 8,
   parameter int DWELL_WIDTH = 12
);
   logic                   start;
   logic                   stop;
   logic [1:0]             mode;
   logic [FREQ_WIDTH-1:0]  f_min;
   logic [FREQ_WIDTH-1:0]  f_max;
   logic [FREQ_WIDTH-1:0]  f_step;
   logic [DWELL_WIDTH-1:0] dwell;
   logic                   nco_en;
   logic [FREQ_WIDTH-1:0]  nco_freq;
   logic                   busy;
   logic                   done;
   logic                   cfg_err;
   logic                   dir;

   modport master (
      output start, stop, mode, f_min, f_max, f_step, dwell,
      input  nco_en, nco_freq, busy, done, cfg_err, dir
   );

   modport slave (
      input  start, stop, mode, f_min, f_max, f_step, dwell,
      output nco_en, nco_freq, busy, done, cfg_err, dir
   );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Sweeps the nco_sin frequency word between f_min and f_max (one-shot, sawtooth or triangle),
// holding each value for a programmable dwell; all outputs registered.
module nco_sweep_ctrl #(
   parameter int FREQ_WIDTH  = 8,
   parameter int DWELL_WIDTH = 12
) (
   input logic              clk,
   input logic              rst,
   nco_sweep_ctrl_if.slave  io_sw
);
   localparam int FW = FREQ_WIDTH;
   localparam int DW = DWELL_WIDTH;
   localparam logic [DW-1:0] DWELL_ONE = DW'(1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t        r_state;
   logic [1:0]    r_mode;
   logic [FW-1:0] r_f_min;
   logic [FW-1:0] r_f_max;
   logic [FW-1:0] r_f_step;
   logic [FW-1:0] r_freq;
   logic [DW-1:0] r_reload;
   logic [DW-1:0] r_cnt;
   logic          r_en;
   logic          r_busy;
   logic          r_done;
   logic          r_cfg_err;
   logic          r_dir;

   logic [FW:0]   w_up_sum;
   logic [FW:0]   w_dn_diff;
   logic [FW-1:0] w_up_nxt;
   logic [FW-1:0] w_dn_nxt;
   logic [DW-1:0] w_reload;
   logic          w_cfg_bad;

   // One extra bit on the step arithmetic so saturation sees the true sum/difference.
   always_comb begin
      w_up_sum  = {1'b0, r_freq} + {1'b0, r_f_step};
      w_dn_diff = {1'b0, r_freq} - {1'b0, r_f_step};
      w_up_nxt  = (w_up_sum > {1'b0, r_f_max}) ? r_f_max : w_up_sum[FW-1:0];
      w_dn_nxt  = (w_dn_diff[FW] || (w_dn_diff[FW-1:0] < r_f_min)) ? r_f_min : w_dn_diff[FW-1:0];
   end

   assign w_reload  = (io_sw.dwell == '0) ? '0 : io_sw.dwell - DWELL_ONE;
   assign w_cfg_bad = (io_sw.f_min > io_sw.f_max) || (io_sw.f_step == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_mode    <= '0;
         r_f_min   <= '0;
         r_f_max   <= '0;
         r_f_step  <= '0;
         r_freq    <= '0;
         r_reload  <= '0;
         r_cnt     <= '0;
         r_en      <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
         r_dir     <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (io_sw.start && !io_sw.stop) begin
                  if (w_cfg_bad) begin
                     r_cfg_err <= 1'b1;
                  end else begin
                     r_mode   <= io_sw.mode;
                     r_f_min  <= io_sw.f_min;
                     r_f_max  <= io_sw.f_max;
                     r_f_step <= io_sw.f_step;
                     r_reload <= w_reload;
                     r_cnt    <= w_reload;
                     r_freq   <= io_sw.f_min;
                     r_en     <= 1'b1;
                     r_busy   <= 1'b1;
                     r_dir    <= 1'b0;
                     r_state  <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (io_sw.stop) begin
                  r_state <= S_IDLE;
                  r_en    <= 1'b0;
                  r_busy  <= 1'b0;
               end else if (r_cnt != '0) begin
                  r_cnt <= r_cnt - DWELL_ONE;
               end else begin
                  r_cnt <= r_reload;
                  // Landing on f_min while descending turns the triangle back up immediately.
                  if (r_dir) begin
                     r_freq <= w_dn_nxt;
                     r_dir  <= (w_dn_nxt != r_f_min);
                  end else if (r_freq != r_f_max) begin
                     r_freq <= w_up_nxt;
                  end else begin
                     case (r_mode)
                        2'b01: r_freq <= r_f_min;
                        2'b10: begin
                           r_freq <= w_dn_nxt;
                           r_dir  <= (w_dn_nxt != r_f_min);
                        end
                        default: begin
                           r_state <= S_DONE;
                           r_done  <= 1'b1;
                           r_en    <= 1'b0;
                           r_busy  <= 1'b0;
                        end
                     endcase
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign io_sw.nco_en   = r_en;
   assign io_sw.nco_freq = r_freq;
   assign io_sw.busy     = r_busy;
   assign io_sw.done     = r_done;
   assign io_sw.cfg_err  = r_cfg_err;
   assign io_sw.dir      = r_dir;
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: directed scenarios plus random sweeps checked against a
// trajectory model that lists the sequence of held frequency values for each run.
module tb_nco_sweep_ctrl;
   localparam int FW = 8;
   localparam int DW = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Held values of one run (one-shot) or one period (cyclic modes), with direction.
   int exp_q[$];
   int exp_dir[$];

   always #5 clk = ~clk;

   nco_sweep_ctrl_if #(.FREQ_WIDTH(FW), .DWELL_WIDTH(DW)) sw ();

   nco_sweep_ctrl #(.FREQ_WIDTH(FW), .DWELL_WIDTH(DW)) dut (
      .clk   (clk),
      .rst   (rst),
      .io_sw (sw.slave)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic chk_outs(input int en, input int busy, input int done, input int cerr,
                           input int freq, input bit dir_vld, input int dir);
      chk("nco_en",   32'(sw.nco_en),   en);
      chk("busy",     32'(sw.busy),     busy);
      chk("done",     32'(sw.done),     done);
      chk("cfg_err",  32'(sw.cfg_err),  cerr);
      chk("nco_freq", 32'(sw.nco_freq), freq);
      if (dir_vld) chk("dir", 32'(sw.dir), dir);
   endtask

   task automatic build_traj(input int md, input int fmin, input int fmax, input int step);
      int f;
      exp_q.delete();
      exp_dir.delete();
      f = fmin;
      exp_q.push_back(f);
      exp_dir.push_back(0);
      while (f < fmax) begin
         f = (f + step > fmax) ? fmax : f + step;
         exp_q.push_back(f);
         exp_dir.push_back(0);
      end
      if (md == 2) begin
         while (f > fmin) begin
            f = (f - step < fmin) ? fmin : f - step;
            if (f != fmin) begin
               exp_q.push_back(f);
               exp_dir.push_back(1);
            end
         end
      end
   endtask

   task automatic set_cfg(input int md, input int fmin, input int fmax, input int step, input int dw);
      sw.mode   = 2'(md);
      sw.f_min  = FW'(fmin);
      sw.f_max  = FW'(fmax);
      sw.f_step = FW'(step);
      sw.dwell  = DW'(dw);
   endtask

   // Starts a sweep, observes ncyc cycles, optional stop at cycle stop_at (-1 = none),
   // optional noise on start/config while running; leaves the DUT idle.
   task automatic run_sweep(input int md, input int fmin, input int fmax, input int step,
                            input int dw, input int ncyc, input int stop_at, input bit noise);
      int  d;
      int  len;
      int  idx;
      int  stopped_freq;
      bit  cyc;
      bit  running;
      cyc = (md == 1) || (md == 2);
      build_traj(md, fmin, fmax, step);
      d = (dw == 0) ? 1 : dw;
      len = exp_q.size();
      stopped_freq = 0;
      set_cfg(md, fmin, fmax, step, dw);
      sw.start = 1'b1;
      sw.stop  = 1'b0;
      for (int t = 0; t < ncyc; t++) begin
         @(negedge clk);
         sw.start = 1'b0;
         sw.stop  = 1'b0;
         running = 1'b0;
         if (stop_at >= 0 && t > stop_at) begin
            chk_outs(0, 0, 0, 0, stopped_freq, 1'b0, 0);
         end else if (!cyc && t == len * d) begin
            chk_outs(0, 0, 1, 0, fmax, 1'b0, 0);
         end else if (!cyc && t > len * d) begin
            chk_outs(0, 0, 0, 0, fmax, 1'b0, 0);
         end else begin
            running = 1'b1;
            idx = t / d;
            if (cyc) idx = idx % len;
            chk_outs(1, 1, 0, 0, exp_q[idx], 1'b1, exp_dir[idx]);
            if (t == stop_at) stopped_freq = exp_q[idx];
         end
         if (t == stop_at) sw.stop = 1'b1;
         if (noise && running) begin
            sw.start = 1'($urandom);
            set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 7)));
         end
      end
      sw.start = 1'b0;
      sw.stop  = 1'b1;
      @(negedge clk);
      sw.stop = 1'b0;
      chk("idle_busy", 32'(sw.busy), 0);
   endtask

   task automatic cfg_reject(input int fmin, input int fmax, input int step, input bit with_stop);
      set_cfg(0, fmin, fmax, step, 3);
      sw.start = 1'b1;
      sw.stop  = with_stop;
      @(negedge clk);
      sw.start = 1'b0;
      sw.stop  = 1'b0;
      chk("rej_cfg_err", 32'(sw.cfg_err), with_stop ? 0 : 1);
      chk("rej_busy",    32'(sw.busy),    0);
      chk("rej_en",      32'(sw.nco_en),  0);
      @(negedge clk);
      chk("rej_cfg_err_pulse", 32'(sw.cfg_err), 0);
      chk("rej_busy2",   32'(sw.busy),    0);
   endtask

   initial begin
      int md, fmin, fmax, step, dw, ncyc, stop_at, limit;
      sw.start = 1'b0;
      sw.stop  = 1'b0;
      set_cfg(0, 0, 0, 0, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_outs(0, 0, 0, 0, 0, 1'b1, 0);
      rst = 1'b0;
      @(negedge clk);
      chk_outs(0, 0, 0, 0, 0, 1'b1, 0);

      // Ramp, triangle, sawtooth without wrap, ramp with stop at cycle 5.
      run_sweep(0, 10, 20, 4, 3, 16, -1, 1'b0);
      run_sweep(2, 10, 20, 4, 3, 30, -1, 1'b0);
      run_sweep(1, 0, 255, 100, 0, 12, -1, 1'b0);
      run_sweep(0, 10, 20, 4, 3, 12, 4, 1'b0);
      run_sweep(3, 50, 50, 9, 2, 6, -1, 1'b0);
      run_sweep(2, 77, 77, 5, 1, 8, -1, 1'b0);
      run_sweep(1, 200, 255, 255, 2, 10, -1, 1'b1);

      cfg_reject(30, 20, 4, 1'b0);
      cfg_reject(10, 20, 0, 1'b0);
      cfg_reject(10, 20, 4, 1'b1);
      cfg_reject(30, 20, 4, 1'b1);

      // Reset while descending in triangle mode, then a clean restart.
      set_cfg(2, 10, 20, 4, 3);
      sw.start = 1'b1;
      @(negedge clk);
      sw.start = 1'b0;
      repeat (13) @(negedge clk);
      chk("pre_rst_dir", 32'(sw.dir), 1);
      rst = 1'b1;
      @(negedge clk);
      chk_outs(0, 0, 0, 0, 0, 1'b1, 0);
      rst = 1'b0;
      run_sweep(2, 10, 20, 4, 3, 20, -1, 1'b0);

      for (int r = 0; r < 30; r++) begin
         md   = int'($urandom_range(0, 3));
         fmin = int'($urandom_range(0, 255));
         fmax = ($urandom_range(0, 5) == 0) ? fmin : int'($urandom_range(fmin, 255));
         step = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 255)) : int'($urandom_range(1, 40));
         dw   = int'($urandom_range(0, 4));
         build_traj(md, fmin, fmax, step);
         if (md == 1 || md == 2) begin
            ncyc  = int'($urandom_range(20, 200));
            limit = ncyc - 2;
         end else begin
            limit = exp_q.size() * ((dw == 0) ? 1 : dw);
            ncyc  = limit + 3;
         end
         stop_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, limit - 1)) : -1;
         run_sweep(md, fmin, fmax, step, dw, ncyc, stop_at, 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
